// File: rtl/id_ex_stage_pkg.sv
// Definitions shared across the core: ALU op encodings, NOP word, field widths.
package id_ex_stage_pkg;
  localparam int REG_W  = 5;
  localparam int TNEW_W = 2;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b010;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Cycles-until-result shrinks by one per stage but never wraps below zero.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand bypass select: $0 is hard zero, then MEM, then WB, then the register value.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [REG_W-1:0] addr,
  input  logic [WIDTH-1:0] reg_val,
  input  logic             m_en,
  input  logic [REG_W-1:0] m_addr,
  input  logic [WIDTH-1:0] m_val,
  input  logic             w_en,
  input  logic [REG_W-1:0] w_addr,
  input  logic [WIDTH-1:0] w_val,
  output logic [WIDTH-1:0] operand
);
  always_comb begin
    operand = reg_val;
    if (addr == '0)                   operand = '0;
    else if (m_en && m_addr == addr)  operand = m_val;  // MEM holds the younger result
    else if (w_en && w_addr == addr)  operand = w_val;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding onto the ALU operands and store data.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [31:0]       d_pc,
  input  logic [31:0]       d_instr,
  input  logic [WIDTH-1:0]  d_rs_val,
  input  logic [WIDTH-1:0]  d_rt_val,
  input  logic [WIDTH-1:0]  d_ext_imm,
  input  logic [OP_W-1:0]   d_alu_op,
  input  logic              d_alu_src_b,
  input  logic [REG_W-1:0]  d_wa,
  input  logic              d_reg_write,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              m_fwd_en,
  input  logic [REG_W-1:0]  m_fwd_addr,
  input  logic [WIDTH-1:0]  m_fwd_val,
  input  logic              w_fwd_en,
  input  logic [REG_W-1:0]  w_fwd_addr,
  input  logic [WIDTH-1:0]  w_fwd_val,
  output logic [OP_W-1:0]   e_alu_op,
  output logic [WIDTH-1:0]  e_alu_a,
  output logic [WIDTH-1:0]  e_alu_b,
  output logic [WIDTH-1:0]  e_rt_fwd,
  output logic [31:0]       e_pc,
  output logic [31:0]       e_instr,
  output logic [REG_W-1:0]  e_wa,
  output logic              e_reg_write,
  output logic [TNEW_W-1:0] e_tnew,
  output logic [REG_W-1:0]  e_rs_addr,
  output logic [REG_W-1:0]  e_rt_addr
);
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [WIDTH-1:0]  rs_val;
    logic [WIDTH-1:0]  rt_val;
    logic [WIDTH-1:0]  ext_imm;
    logic [OP_W-1:0]   alu_op;
    logic              alu_src_b;
    logic [REG_W-1:0]  wa;
    logic              reg_write;
    logic [TNEW_W-1:0] tnew;
  } idex_t;

  idex_t q;
  logic [WIDTH-1:0] rs_fwd, rt_fwd;

  // An all-zero entry is a bubble: sll $0 nop, ADD, no write-back.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      q <= '0;
    end else begin
      q.pc        <= d_pc;
      q.instr     <= d_instr;
      q.rs_val    <= d_rs_val;
      q.rt_val    <= d_rt_val;
      q.ext_imm   <= d_ext_imm;
      q.alu_op    <= d_alu_op;
      q.alu_src_b <= d_alu_src_b;
      q.wa        <= d_wa;
      q.reg_write <= d_reg_write;
      q.tnew      <= tnew_dec(d_tnew);
    end
  end

  assign e_rs_addr = q.instr[25:21];
  assign e_rt_addr = q.instr[20:16];

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_rs (
    .addr(e_rs_addr), .reg_val(q.rs_val),
    .m_en(m_fwd_en), .m_addr(m_fwd_addr), .m_val(m_fwd_val),
    .w_en(w_fwd_en), .w_addr(w_fwd_addr), .w_val(w_fwd_val),
    .operand(rs_fwd)
  );

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_rt (
    .addr(e_rt_addr), .reg_val(q.rt_val),
    .m_en(m_fwd_en), .m_addr(m_fwd_addr), .m_val(m_fwd_val),
    .w_en(w_fwd_en), .w_addr(w_fwd_addr), .w_val(w_fwd_val),
    .operand(rt_fwd)
  );

  assign e_alu_op    = q.alu_op;
  assign e_alu_a     = rs_fwd;
  assign e_alu_b     = q.alu_src_b ? q.ext_imm : rt_fwd;
  assign e_rt_fwd    = rt_fwd;
  assign e_pc        = q.pc;
  assign e_instr     = q.instr;
  assign e_wa        = q.wa;
  assign e_reg_write = q.reg_write;
  assign e_tnew      = q.tnew;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: behavioural model checked every cycle plus literal spot checks.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] d_pc, d_instr, d_rs_val, d_rt_val, d_ext_imm;
  logic [2:0]  d_alu_op;
  logic        d_alu_src_b;
  logic [4:0]  d_wa;
  logic        d_reg_write;
  logic [1:0]  d_tnew;
  logic        m_fwd_en, w_fwd_en;
  logic [4:0]  m_fwd_addr, w_fwd_addr;
  logic [31:0] m_fwd_val, w_fwd_val;
  logic [2:0]  e_alu_op;
  logic [31:0] e_alu_a, e_alu_b, e_rt_fwd, e_pc, e_instr;
  logic [4:0]  e_wa, e_rs_addr, e_rt_addr;
  logic        e_reg_write;
  logic [1:0]  e_tnew;

  id_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .d_pc(d_pc), .d_instr(d_instr), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
    .d_ext_imm(d_ext_imm), .d_alu_op(d_alu_op), .d_alu_src_b(d_alu_src_b),
    .d_wa(d_wa), .d_reg_write(d_reg_write), .d_tnew(d_tnew),
    .m_fwd_en(m_fwd_en), .m_fwd_addr(m_fwd_addr), .m_fwd_val(m_fwd_val),
    .w_fwd_en(w_fwd_en), .w_fwd_addr(w_fwd_addr), .w_fwd_val(w_fwd_val),
    .e_alu_op(e_alu_op), .e_alu_a(e_alu_a), .e_alu_b(e_alu_b), .e_rt_fwd(e_rt_fwd),
    .e_pc(e_pc), .e_instr(e_instr), .e_wa(e_wa), .e_reg_write(e_reg_write),
    .e_tnew(e_tnew), .e_rs_addr(e_rs_addr), .e_rt_addr(e_rt_addr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what instruction sits in EX, kept as plain fields.
  logic [31:0] m_pc, m_instr, m_rs, m_rt, m_imm;
  logic [2:0]  m_op;
  logic        m_srcb, m_rw, m_valid = 1'b0;
  logic [4:0]  m_wa;
  logic [1:0]  m_tnew;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (reset || stall) begin
      {m_pc, m_instr, m_rs, m_rt, m_imm} <= '0;
      {m_op, m_srcb, m_wa, m_rw, m_tnew} <= '0;
    end else begin
      m_pc <= d_pc; m_instr <= d_instr; m_rs <= d_rs_val; m_rt <= d_rt_val;
      m_imm <= d_ext_imm; m_op <= d_alu_op; m_srcb <= d_alu_src_b;
      m_wa <= d_wa; m_rw <= d_reg_write;
      m_tnew <= (d_tnew > 2'd0) ? d_tnew - 2'd1 : 2'd0;
    end
  end

  // Newest-first search of the bypass sources; $0 is constant zero.
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rv);
    if (a == 5'd0) return 32'd0;
    if (m_fwd_en && m_fwd_addr == a) return m_fwd_val;
    if (w_fwd_en && w_fwd_addr == a) return w_fwd_val;
    return rv;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      logic [31:0] rs_o, rt_o;
      rs_o = operand(m_instr[25:21], m_rs);
      rt_o = operand(m_instr[20:16], m_rt);
      chk("m_alu_op",    {29'd0, e_alu_op},    {29'd0, m_op});
      chk("m_alu_a",     e_alu_a,              rs_o);
      chk("m_alu_b",     e_alu_b,              m_srcb ? m_imm : rt_o);
      chk("m_rt_fwd",    e_rt_fwd,             rt_o);
      chk("m_pc",        e_pc,                 m_pc);
      chk("m_instr",     e_instr,              m_instr);
      chk("m_wa",        {27'd0, e_wa},        {27'd0, m_wa});
      chk("m_reg_write", {31'd0, e_reg_write}, {31'd0, m_rw});
      chk("m_tnew",      {30'd0, e_tnew},      {30'd0, m_tnew});
      chk("m_rs_addr",   {27'd0, e_rs_addr},   {27'd0, m_instr[25:21]});
      chk("m_rt_addr",   {27'd0, e_rt_addr},   {27'd0, m_instr[20:16]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, instr, rs, rt, imm, input logic [2:0] op,
                        input logic srcb, input logic [4:0] wa, input logic rw, input logic [1:0] tn);
    d_pc = pc; d_instr = instr; d_rs_val = rs; d_rt_val = rt; d_ext_imm = imm;
    d_alu_op = op; d_alu_src_b = srcb; d_wa = wa; d_reg_write = rw; d_tnew = tn;
  endtask

  task automatic set_fwd(input logic me, input logic [4:0] ma, input logic [31:0] mv,
                         input logic we, input logic [4:0] wa, input logic [31:0] wv);
    m_fwd_en = me; m_fwd_addr = ma; m_fwd_val = mv;
    w_fwd_en = we; w_fwd_addr = wa; w_fwd_val = wv;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    set_id(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // Reset for two cycles with addu $3,$1,$2 waiting in ID.
    set_id(32'h0000_0000, 32'h0022_1821, 32'h11, 32'h22, 32'h0, 3'b000, 1'b0, 5'd3, 1'b1, 2'd1);
    step();
    step();
    chk("rst_instr", e_instr, 32'd0);
    chk("rst_alu_a", e_alu_a, 32'd0);
    chk("rst_alu_b", e_alu_b, 32'd0);
    chk("rst_pc",    e_pc,    32'd0);
    chk("rst_rw",    {31'd0, e_reg_write}, 32'd0);
    reset = 1'b0;
    step();
    chk("addu_instr", e_instr, 32'h0022_1821);
    chk("addu_wa",    {27'd0, e_wa}, 32'd3);
    chk("addu_rw",    {31'd0, e_reg_write}, 32'd1);

    // ori $4,$1,0x00FF
    set_id(32'h4, 32'h3424_00FF, 32'h1234_0000, 32'h0, 32'hFF, 3'b010, 1'b1, 5'd4, 1'b1, 2'd2);
    step();
    chk("ori_alu_a", e_alu_a, 32'h1234_0000);
    chk("ori_alu_b", e_alu_b, 32'h0000_00FF);
    chk("ori_op",    {29'd0, e_alu_op}, 32'd2);
    chk("ori_tnew",  {30'd0, e_tnew}, 32'd1);

    // addu $6,$5,$0: MEM vs WB priority on rs, then $0 immunity on rt.
    set_id(32'h8, 32'h00A0_3021, 32'h1, 32'h2222, 32'h0, 3'b000, 1'b0, 5'd6, 1'b1, 2'd1);
    step();
    set_fwd(1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'h0000_5555);
    #1 chk("fwd_mem_wins", e_alu_a, 32'hAAAA_0000);
    m_fwd_en = 1'b0;
    #1 chk("fwd_wb",       e_alu_a, 32'h0000_5555);
    set_fwd(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd5, 32'h0000_5555);
    #1 chk("zero_alu_b",   e_alu_b, 32'd0);
    chk("zero_rt_fwd",     e_rt_fwd, 32'd0);
    chk("wb_disabled",     e_alu_a, 32'h1);

    // lw $8,4($9) held under a 3-cycle stall.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(32'hC, 32'h8D28_0004, 32'h100, 32'h0, 32'h4, 3'b000, 1'b1, 5'd8, 1'b1, 2'd3);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", e_instr, 32'd0);
      chk("stall_rw",    {31'd0, e_reg_write}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("lw_instr", e_instr, 32'h8D28_0004);
    chk("lw_wa",    {27'd0, e_wa}, 32'd8);
    chk("lw_tnew",  {30'd0, e_tnew}, 32'd2);

    // Reset and stall together discard the held lw.
    reset = 1'b1; stall = 1'b1;
    step();
    chk("mid_rst_instr", e_instr, 32'd0);
    chk("mid_rst_pc",    e_pc, 32'd0);
    reset = 1'b0; stall = 1'b0;

    // sw $7,8($2) with $7 bypassed from WB.
    set_id(32'h10, 32'hAC47_0008, 32'h1000, 32'h0, 32'h8, 3'b000, 1'b1, 5'd0, 1'b0, 2'd2);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    step();
    chk("sw_alu_b",  e_alu_b,  32'h8);
    chk("sw_rt_fwd", e_rt_fwd, 32'hDEAD_BEEF);
    chk("sw_alu_a",  e_alu_a,  32'h1000);
    chk("sw_tnew",   {30'd0, e_tnew}, 32'd1);

    // tnew 0 saturates; undefined op code passes through.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(32'h14, 32'h0022_1821, 32'h7, 32'h9, 32'h0, 3'b111, 1'b0, 5'd3, 1'b1, 2'd0);
    step();
    chk("tnew_sat", {30'd0, e_tnew}, 32'd0);
    chk("undef_op", {29'd0, e_alu_op}, 32'd7);
    chk("rt_plain", e_alu_b, 32'h9);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
